// File: rtl/reset_seq_pkg.sv
// Shared constants for the reset sequencer: FSM state encodings and a
// constant-evaluable ceil(log2) helper.
package reset_seq_pkg;

    localparam int SEQ_STATE_W = 2;

    localparam logic [SEQ_STATE_W-1:0] ST_HOLD    = 2'd0;
    localparam logic [SEQ_STATE_W-1:0] ST_RELEASE = 2'd1;
    localparam logic [SEQ_STATE_W-1:0] ST_DONE    = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Reset synchroniser: asserts asynchronously and deasserts after STAGES
// rising edges. It is reusable in any clock domain.
module rst_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    output logic rst_sync_n
);

    if (STAGES < 2) begin : g_bad_stages
        $error("rst_sync_cell: STAGES must be >= 2");
    end

    logic [STAGES-1:0] r_chain;

    // shift ones in after release; any rstn low clears the whole chain at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset controller. Define RST_SEQ_SW_REQ_EN to enable the
// synchronous soft-reset request. Without it, sw_rst_req is ignored.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int MIN_HOLD    = 32,
    parameter int RELEASE_GAP = 16,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sw_rst_req,
    output logic [NUM_CH-1:0]      rstn_out,
    output logic                   seq_done,
    output logic [SEQ_STATE_W-1:0] seq_state
);

    localparam int MAX_REQ = (MIN_HOLD > RELEASE_GAP) ? MIN_HOLD : RELEASE_GAP;
    localparam int IDX_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    if ((64'd1 << CNT_W) <= 64'(MAX_REQ)) begin : g_bad_cnt_w
        $error("reset_sequencer: CNT_W too small for MIN_HOLD/RELEASE_GAP");
    end
    if (NUM_CH < 1 || MIN_HOLD < 1 || RELEASE_GAP < 1) begin : g_bad_param
        $error("reset_sequencer: NUM_CH, MIN_HOLD and RELEASE_GAP must be >= 1");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic                   w_sync_n;
    logic                   w_soft;
    logic                   w_qual;
    logic [SEQ_STATE_W-1:0] r_state;
    logic [SEQ_STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [IDX_W-1:0]       r_ch_idx;
    logic [IDX_W-1:0]       w_ch_idx_nxt;
    logic [IDX_W-1:0]       w_ch_inc;
    logic [NUM_CH-1:0]      r_rstn_out;
    logic [NUM_CH-1:0]      w_rstn_out_nxt;
    logic                   r_seq_done;
    logic                   w_seq_done_nxt;

    rst_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .rst_sync_n (w_sync_n)
    );

`ifdef RST_SEQ_SW_REQ_EN
    assign w_soft = sw_rst_req;
`else
    logic w_unused_sw_rst_req;
    assign w_unused_sw_rst_req = sw_rst_req;
    assign w_soft              = 1'b0;
`endif

    assign w_qual    = w_sync_n & ~w_soft;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_ch_inc  = r_ch_idx + 1'b1;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        if (w_soft) begin
            w_state_nxt = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_qual && r_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_RELEASE: begin
                    if (r_ch_idx == IDX_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_HOLD;
            endcase
        end
    end

    // next values of the counter, channel index and output flops
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_ch_idx_nxt   = r_ch_idx;
        w_rstn_out_nxt = r_rstn_out;
        w_seq_done_nxt = r_seq_done;
        if (w_soft) begin
            w_cnt_nxt      = '0;
            w_ch_idx_nxt   = '0;
            w_rstn_out_nxt = '0;
            w_seq_done_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_qual && r_cnt == HOLD_LAST) begin
                        w_cnt_nxt         = '0;
                        w_ch_idx_nxt      = '0;
                        w_rstn_out_nxt[0] = 1'b1;
                    end else if (w_qual) begin
                        w_cnt_nxt = w_cnt_inc;
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_RELEASE: begin
                    if (r_ch_idx == IDX_LAST) begin
                        w_seq_done_nxt = 1'b1;
                    end else if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt    = '0;
                        w_ch_idx_nxt = w_ch_inc;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (IDX_W'(k) == w_ch_inc) begin
                                w_rstn_out_nxt[k] = 1'b1;
                            end else begin
                                w_rstn_out_nxt[k] = r_rstn_out[k];
                            end
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    w_cnt_nxt = r_cnt;
                end
                default: begin
                    // illegal encoding: restart the sequence from a clean state
                    w_cnt_nxt      = '0;
                    w_ch_idx_nxt   = '0;
                    w_rstn_out_nxt = '0;
                    w_seq_done_nxt = 1'b0;
                end
            endcase
        end
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_ch_idx   <= '0;
            r_rstn_out <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ch_idx   <= w_ch_idx_nxt;
            r_rstn_out <= w_rstn_out_nxt;
            r_seq_done <= w_seq_done_nxt;
        end
    end

    assign rstn_out  = r_rstn_out;
    assign seq_done  = r_seq_done;
    assign seq_state = r_state;

endmodule
